// File: rtl/perceptron_axil_sequencer.sv
// AXI4-Lite master that drives one full inference on the perceptron slave:
// clear, N x (X, W, ACC), eval, then polls RESULT until READY or timeout.
//
// state     | meaning
// S_IDLE    | waiting for start; result/err hold last outcome
// S_WR_ADDR | AW and W offered, each drops on its own handshake
// S_WR_RESP | BREADY high, waiting for write response
// S_RD_ADDR | ARVALID high on RESULT address
// S_RD_RESP | RREADY high, waiting for read data
// S_DONE    | one-cycle done pulse
module perceptron_axil_sequencer #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter int          C_N_FEAT           = 4,
    parameter int          C_POLL_LIMIT       = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          start,
    input  logic [C_N_FEAT*32-1:0]        x_vec,
    input  logic [C_N_FEAT*32-1:0]        w_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [31:0]                   result,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_RESP, S_DONE
    } state_t;

    typedef enum logic [2:0] {K_CLR, K_X, K_W, K_ACC, K_EVAL} kind_t;

    localparam int IDX_W = (C_N_FEAT > 1) ? $clog2(C_N_FEAT) : 1;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_X    = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_W    = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + 32'h4);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_CTRL = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + 32'h8);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_RES  = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR + 32'hC);

    state_t                          r_state, w_next;
    kind_t                           r_kind, w_nxt_kind;
    logic [IDX_W-1:0]                r_idx, w_nxt_idx;
    logic [31:0]                     r_x [C_N_FEAT];
    logic [31:0]                     r_w [C_N_FEAT];
    logic                            r_aw_done, r_w_done;
    logic [7:0]                      r_poll;
    logic [7:0]                      w_poll_inc;
    logic                            r_err;
    logic [31:0]                     r_result;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr, r_araddr, w_nxt_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata, w_nxt_data;
    logic                            w_aw_hs, w_w_hs, w_rd_fail;

    assign w_poll_inc = r_poll + 8'd1;
    assign w_aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs     = M_AXI_WVALID & M_AXI_WREADY;
    // Poll limit only matters when READY is still clear on this read.
    assign w_rd_fail  = (M_AXI_RRESP != 2'b00) ||
                        (!M_AXI_RDATA[31] && (w_poll_inc == 8'(C_POLL_LIMIT)));

    assign M_AXI_AWADDR = r_awaddr;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_ARADDR = r_araddr;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'hF;
    assign err          = r_err;
    assign result       = r_result;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                busy          = 1'b1;
                M_AXI_AWVALID = !r_aw_done;
                M_AXI_WVALID  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                busy         = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) w_next = S_DONE;
                    else if (r_kind == K_EVAL) w_next = S_RD_ADDR;
                    else                       w_next = S_WR_ADDR;
                end
            end
            S_RD_ADDR: begin
                busy          = 1'b1;
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) w_next = S_RD_RESP;
            end
            S_RD_RESP: begin
                busy         = 1'b1;
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    if (w_rd_fail || M_AXI_RDATA[31]) w_next = S_DONE;
                    else                              w_next = S_RD_ADDR;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Successor of the current write in the CLR, (X, W, ACC) x N, EVAL chain.
    always_comb begin
        w_nxt_kind = K_EVAL;
        w_nxt_idx  = r_idx;
        case (r_kind)
            K_CLR: begin
                w_nxt_kind = K_X;
                w_nxt_idx  = '0;
            end
            K_X:   w_nxt_kind = K_W;
            K_W:   w_nxt_kind = K_ACC;
            K_ACC: begin
                if (r_idx != IDX_W'(C_N_FEAT - 1)) begin
                    w_nxt_kind = K_X;
                    w_nxt_idx  = r_idx + 1'b1;
                end
            end
            default: ;
        endcase
        w_nxt_addr = A_CTRL;
        w_nxt_data = 32'h4;
        case (w_nxt_kind)
            K_X: begin
                w_nxt_addr = A_X;
                w_nxt_data = r_x[w_nxt_idx];
            end
            K_W: begin
                w_nxt_addr = A_W;
                w_nxt_data = r_w[w_nxt_idx];
            end
            K_ACC:   w_nxt_data = 32'h1;
            K_CLR:   w_nxt_data = 32'h2;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (r_state == S_IDLE && start) begin
            for (int i = 0; i < C_N_FEAT; i++) begin
                r_x[i] <= x_vec[32*i +: 32];
                r_w[i] <= w_vec[32*i +: 32];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_kind    <= K_CLR;
            r_idx     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_poll    <= 8'd0;
            r_err     <= 1'b0;
            r_result  <= 32'd0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err     <= 1'b0;
                        r_poll    <= 8'd0;
                        r_idx     <= '0;
                        r_kind    <= K_CLR;
                        r_awaddr  <= A_CTRL;
                        r_wdata   <= 32'h2;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                S_WR_ADDR: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        if (M_AXI_BRESP != 2'b00) begin
                            r_err <= 1'b1;
                        end else if (r_kind == K_EVAL) begin
                            r_araddr <= A_RES;
                        end else begin
                            r_kind    <= w_nxt_kind;
                            r_idx     <= w_nxt_idx;
                            r_awaddr  <= w_nxt_addr;
                            r_wdata   <= w_nxt_data;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        r_result <= M_AXI_RDATA[31:0];
                        r_poll   <= w_poll_inc;
                        if (w_rd_fail) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_axil_sequencer.sv
// Bench for perceptron_axil_sequencer: a behavioural perceptron slave with
// random ready skew, a reference write-sequence/dot-product model, and checks.
module tb_perceptron_axil_sequencer;

    localparam int          N    = 4;
    localparam int          PL   = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic            clk = 1'b0;
    logic            ARESETN = 1'b0;
    logic            start = 1'b0;
    logic [N*32-1:0] x_vec = '0;
    logic [N*32-1:0] w_vec = '0;
    logic            busy, done, err;
    logic [31:0]     result;
    logic [31:0]     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic            M_AXI_AWREADY = 1'b0;
    logic            M_AXI_WREADY  = 1'b0;
    logic [1:0]      M_AXI_BRESP   = 2'b00;
    logic            M_AXI_BVALID  = 1'b0;
    logic            M_AXI_ARREADY = 1'b0;
    logic [31:0]     M_AXI_RDATA   = 32'd0;
    logic [1:0]      M_AXI_RRESP   = 2'b00;
    logic            M_AXI_RVALID  = 1'b0;

    always #5 clk = ~clk;

    perceptron_axil_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(BASE),
        .C_N_FEAT(N), .C_POLL_LIMIT(PL)
    ) dut (
        .ACLK(clk), .ARESETN(ARESETN), .start(start), .x_vec(x_vec), .w_vec(w_vec),
        .busy(busy), .done(done), .err(err), .result(result),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model (acts on negedge, owns its own state) ----------------
    int          mode_skew = 0, ready_at = 1, bad_idx = 0;
    int          cyc = 0;
    logic        aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0;
    logic        aw_got = 0, w_got = 0, ar_got = 0;
    logic [31:0] aw_a = 0, w_d = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    int          ar_cnt = 0, poll_n = 0, done_cnt = 0, done_cyc = -1, b_err_cyc = -100;
    int          viol = 0, hold_err = 0, run_wr = 0;
    int          aw_wait = 0, w_wait = 0, aw_lat = 0, w_lat = 0;
    logic        hold_aw = 0, hold_w = 0;
    logic [31:0] hold_awaddr = 0, hold_wdata = 0;
    logic [31:0] m_x = 0, m_w = 0, last_rdata = 0;
    longint      m_acc = 0;
    logic        m_cls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!ARESETN) begin
            {aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got} = '0;
            {hold_aw, hold_w} = '0;
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        end else begin
            if (!busy) begin
                // first write of a skewed run: W lands 3 cycles before AW
                aw_lat = mode_skew ? 3 : 0; w_lat = 0; aw_wait = 0; w_wait = 0; run_wr = 0;
            end
            if (aw_pend) begin aw_got = 1; aw_pend = 0; end
            if (w_pend)  begin w_got = 1;  w_pend = 0;  end
            if (ar_pend) begin ar_got = 1; ar_pend = 0; end
            if (b_pend)  begin M_AXI_BVALID = 0; b_pend = 0; end
            if (r_pend)  begin M_AXI_RVALID = 0; r_pend = 0; end
            if (aw_got && w_got && !M_AXI_BVALID) begin
                wr_addr_q.push_back(aw_a);
                wr_data_q.push_back(w_d);
                run_wr++;
                poll_n = 0;
                case (aw_a - BASE)
                    32'h0: m_x = w_d;
                    32'h4: m_w = w_d;
                    32'h8: begin
                        if (w_d[1]) m_acc = 0;
                        if (w_d[0]) m_acc += longint'($signed(m_x)) * longint'($signed(m_w));
                        if (w_d[2]) m_cls = (m_acc > 0);
                    end
                    default: viol++;
                endcase
                M_AXI_BRESP  = (run_wr == bad_idx) ? 2'b10 : 2'b00;
                M_AXI_BVALID = 1;
                aw_got = 0; w_got = 0;
            end
            if (ar_got && !M_AXI_RVALID) begin
                poll_n++;
                if (poll_n == ready_at) M_AXI_RDATA = {1'b1, 30'd0, m_cls};
                else                    M_AXI_RDATA = {1'b0, 31'($urandom)};
                last_rdata   = M_AXI_RDATA;
                M_AXI_RRESP  = 2'b00;
                M_AXI_RVALID = 1;
                ar_got = 0;
            end
            if ((M_AXI_AWVALID || M_AXI_ARVALID) && (M_AXI_BVALID || M_AXI_RVALID)) viol++;
            if (M_AXI_AWVALID && M_AXI_ARVALID) viol++;
            if (hold_aw && (!M_AXI_AWVALID || M_AXI_AWADDR !== hold_awaddr)) hold_err++;
            if (hold_w && (!M_AXI_WVALID || M_AXI_WDATA !== hold_wdata)) hold_err++;

            if (M_AXI_AWVALID) begin
                M_AXI_AWREADY = (aw_wait >= aw_lat);
                aw_wait++;
            end else M_AXI_AWREADY = 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_pend = 1; aw_a = M_AXI_AWADDR; aw_wait = 0;
                aw_lat = mode_skew ? $urandom_range(3, 0) : 0;
            end
            if (M_AXI_WVALID) begin
                M_AXI_WREADY = (w_wait >= w_lat);
                w_wait++;
            end else M_AXI_WREADY = 0;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_pend = 1; w_d = M_AXI_WDATA; w_wait = 0;
                w_lat = mode_skew ? $urandom_range(3, 0) : 0;
            end
            M_AXI_ARREADY = mode_skew ? 1'($urandom % 2) : 1'b1;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_pend = 1; ar_cnt++; end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_pend = 1;
                if (M_AXI_BRESP != 2'b00) b_err_cyc = cyc;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_pend = 1;
            hold_aw = M_AXI_AWVALID && !aw_pend; hold_awaddr = M_AXI_AWADDR;
            hold_w  = M_AXI_WVALID && !w_pend;   hold_wdata  = M_AXI_WDATA;
        end
    end

    // ---------------- reference model and driver ----------------
    function automatic logic ref_cls(input logic [N*32-1:0] xv, input logic [N*32-1:0] wv);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(xv[32*i +: 32])) * longint'($signed(wv[32*i +: 32]));
        return s > 0;
    endfunction

    function automatic logic [N*32-1:0] rnd_vec();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom_range(200, 0) - 100;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int wr0, ar0, dc0, v0, h0;

    task automatic run(input string tag, input logic [N*32-1:0] xv, input logic [N*32-1:0] wv,
                       input int skew, input int rdy, input int bad, input int extra);
        int k;
        mode_skew = skew; ready_at = rdy; bad_idx = bad;
        tick(1);
        wr0 = wr_addr_q.size(); ar0 = ar_cnt; dc0 = done_cnt; v0 = viol; h0 = hold_err;
        x_vec = xv; w_vec = wv;
        start = 1; tick(1); start = 0;
        check($sformatf("%s_busy_after_start", tag), busy, 1);
        if (extra != 0) begin
            tick(3); start = 1; tick(1); start = 0;
        end
        k = 0;
        while (!done && k < 3000) begin tick(1); k++; end
        check($sformatf("%s_done_seen", tag), done, 1);
        check($sformatf("%s_busy_in_done", tag), busy, 0);
        start = 1; tick(1); start = 0;
        check($sformatf("%s_start_in_done_ignored", tag), busy, 0);
        tick(3);
        check($sformatf("%s_done_pulses", tag), done_cnt - dc0, 1);
        check($sformatf("%s_protocol", tag), viol - v0, 0);
        check($sformatf("%s_valid_hold", tag), hold_err - h0, 0);
    endtask

    task automatic check_writes(input string tag, input logic [N*32-1:0] xv,
                                input logic [N*32-1:0] wv, input int nexp);
        logic [31:0] ea[$], ed[$];
        ea.push_back(BASE + 8); ed.push_back(32'h2);
        for (int i = 0; i < N; i++) begin
            ea.push_back(BASE);     ed.push_back(xv[32*i +: 32]);
            ea.push_back(BASE + 4); ed.push_back(wv[32*i +: 32]);
            ea.push_back(BASE + 8); ed.push_back(32'h1);
        end
        ea.push_back(BASE + 8); ed.push_back(32'h4);
        check($sformatf("%s_write_count", tag), wr_addr_q.size() - wr0, nexp);
        for (int i = 0; i < nexp && wr0 + i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[wr0 + i], ea[i]);
            check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[wr0 + i], ed[i]);
        end
    endtask

    initial begin
        logic [N*32-1:0] xv, wv;
        int rdy;

        ARESETN = 0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_awvalid", M_AXI_AWVALID, 0);
        check("rst_wvalid", M_AXI_WVALID, 0);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_awaddr", M_AXI_AWADDR, 0);
        check("rst_araddr", M_AXI_ARADDR, 0);
        check("rst_wdata", M_AXI_WDATA, 0);
        check("tie_wstrb", M_AXI_WSTRB, 4'hF);
        ARESETN = 1;
        tick(2);

        xv = {32'd4, 32'd3, 32'd2, 32'd1};
        wv = {32'd8, 32'd7, 32'd6, 32'd5};
        run("basic", xv, wv, 0, 1, 0, 0);
        check_writes("basic", xv, wv, 3*N + 2);
        check("basic_ar_count", ar_cnt - ar0, 1);
        check("basic_result", result, 32'h8000_0001);
        check("basic_err", err, 0);

        for (int t = 0; t < 3; t++) begin
            xv = rnd_vec(); wv = rnd_vec(); rdy = $urandom_range(3, 1);
            run($sformatf("skew%0d", t), xv, wv, 1, rdy, 0, 0);
            check_writes($sformatf("skew%0d", t), xv, wv, 3*N + 2);
            check($sformatf("skew%0d_ar_count", t), ar_cnt - ar0, rdy);
            check($sformatf("skew%0d_result", t), result, {1'b1, 30'd0, ref_cls(xv, wv)});
            check($sformatf("skew%0d_err", t), err, 0);
        end

        xv = rnd_vec(); wv = rnd_vec();
        run("poll5", xv, wv, 0, 5, 0, 0);
        check("poll5_ar_count", ar_cnt - ar0, 5);
        check("poll5_result", result, {1'b1, 30'd0, ref_cls(xv, wv)});
        check("poll5_err", err, 0);

        run("timeout", xv, wv, 0, 0, 0, 0);
        check("timeout_ar_count", ar_cnt - ar0, PL);
        check("timeout_err", err, 1);
        check("timeout_result", result, last_rdata);

        run("bresp", xv, wv, 0, 1, 3, 0);
        check_writes("bresp", xv, wv, 3);
        check("bresp_ar_count", ar_cnt - ar0, 0);
        check("bresp_err", err, 1);
        check("bresp_done_latency", done_cyc - b_err_cyc, 1);

        // reset while the first write is stalled on AWREADY
        mode_skew = 1; ready_at = 1; bad_idx = 0;
        tick(2);
        x_vec = rnd_vec(); w_vec = rnd_vec();
        start = 1; tick(1); start = 0;
        check("rstmid_awvalid_before", M_AXI_AWVALID, 1);
        tick(1);
        ARESETN = 0;
        tick(1);
        check("rstmid_awvalid", M_AXI_AWVALID, 0);
        check("rstmid_wvalid", M_AXI_WVALID, 0);
        check("rstmid_arvalid", M_AXI_ARVALID, 0);
        check("rstmid_bready", M_AXI_BREADY, 0);
        check("rstmid_busy", busy, 0);
        ARESETN = 1;
        tick(1);
        xv = rnd_vec(); wv = rnd_vec();
        run("after_rst", xv, wv, 0, 1, 0, 1);
        check_writes("after_rst", xv, wv, 3*N + 2);
        check("after_rst_result", result, {1'b1, 30'd0, ref_cls(xv, wv)});
        check("after_rst_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perceptron_axil_sequencer.md
Name: perceptron_axil_sequencer

Overview:
- AXI4-Lite master that runs one complete inference on the axi_perceptron slave.
- On a single start pulse it captures a feature vector and a weight vector, then programs the slave in this order: clear, N multiply-accumulate steps, evaluate.
- It then polls the slave's result register and returns the result with a done pulse.
- Sits between local control logic (CPU-less test/system harness) and the perceptron's S00_AXI port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of the master port.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_BASE_ADDR, 32'h00000000, base address of the perceptron slave.
- C_N_FEAT, 4, number of features per inference (1..16).
- C_POLL_LIMIT, 16, maximum result-register reads before timeout (1..255).

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- x_vec  in  C_N_FEAT*32  feature vector; element i is in bits [32i+31:32i].
- w_vec  in  C_N_FEAT*32  weight vector, same packing as x_vec.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: bad response or poll timeout.
- result  out  32  last read data from the result register; held until the next start.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  tied 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  tied 4'hF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response code.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  tied 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response code.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Slave register map, offsets from C_BASE_ADDR:
  - 0x0 X
  - 0x4 W
  - 0x8 CTRL: bit0 ACC, bit1 CLR, bit2 EVAL
  - 0xC RESULT: bit31 READY, bit0 class
- Reset (ARESETN low at an edge): next-cycle state is IDLE; all VALID/READY outputs 0; busy, done, err 0; result 0; AWADDR, ARADDR, WDATA 0; idx 0; poll count 0.
- Reset mid-transaction drops VALIDs immediately; no completion is owed.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE.
- Write sequence, with idx from 0 to C_N_FEAT-1:
  - CTRL=0x2
  - for each idx: X=x[idx], W=w[idx], CTRL=0x1
  - finally CTRL=0x4
  - Total 3*C_N_FEAT+2 writes, issued strictly one at a time.
- IDLE:
  - start=1 registers x_vec and w_vec, sets busy, loads the first write, and enters WR_ADDR.
  - AWVALID and WVALID rise the cycle after start is sampled.
  - start outside IDLE is ignored.
- WR_ADDR:
  - AWVALID and WVALID are asserted together.
  - Each drops independently on its own handshake (VALID&READY at an edge); AW and W may complete in either order or in the same cycle.
  - After both have completed: enter WR_RESP with BREADY=1.
  - Address, data and VALID are stable while VALID is high.
- WR_RESP, on BVALID:
  - BRESP!=0: set err, go to DONE.
  - otherwise load the next write and go to WR_ADDR, or go to RD_ADDR after the EVAL write.
- RD_ADDR:
  - ARADDR=base+0xC, ARVALID=1 until ARREADY, then RD_RESP with RREADY=1.
- RD_RESP, on RVALID:
  - result<=RDATA and poll count increments.
  - RRESP!=0: err, DONE.
  - RDATA[31]=1: DONE with err=0.
  - poll count==C_POLL_LIMIT: err, DONE.
  - otherwise back to RD_ADDR.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- A start in the DONE cycle is ignored.
- Never more than one outstanding transaction; no AW or AR is issued while a response is pending.
- err is cleared when a start is accepted.

Test Plan:
- N=4, zero-wait slave model; x={1,2,3,4}, w={5,6,7,8}:
  - exactly 14 writes, in order CTRL=2, (X,W,CTRL=1)x4, CTRL=4;
  - RESULT read returns 0x80000001 on the first poll;
  - result=0x80000001, err=0, done a single cycle.
- Random AWREADY/WREADY skew, including W accepted 3 cycles before AW:
  - same 14-write order;
  - AWADDR and WDATA stable while VALID is high.
- RESULT READY first set on the 5th read: exactly 5 AR handshakes, result=last RDATA, err=0.
- READY never set, C_POLL_LIMIT=16: 16 reads, then done with err=1 and result=last read value.
- BRESP=2'b10 on the 3rd write: no further AW or AR issued; done with err=1 on the next cycle after B.
- ARESETN low during WR_ADDR with VALID high:
  - all VALIDs 0 and busy 0 next cycle.
  - a subsequent start runs a complete 14-write sequence.
  - a start pulse issued while busy has no effect.
